time_entry: RTL and testbench
=============================

# time_entry

User-input front end for the countdown timer: debounces four push-buttons, lets the operator edit a two-digit BCD minute preset, and drives the timer's preset/load/enable side (`I1`, `I0`, `load`, `CE`). It sits between the board buttons and the timer top, on the same fast board clock as the 1 Hz divider. It also runs, pauses and returns the timer to idle based on the timer's `LED` (done) output.

## Interface

Parameters:
- `DB_CYCLES`, default 1_000_000: cycles a raw button must be stable before its debounced level changes (10 ms at 100 MHz).
- `LOAD_CYCLES`, default 100_000_000: cycles `load` is held high, so it spans at least one full 1 Hz timer tick.

Ports:
- `clk`, in, 1: board clock.
- `reset`, in, 1: asynchronous, active-low; the whole block is in reset while low.
- `btn_mode`, in, 1: raw, asynchronous, active-high; selects the digit to edit.
- `btn_up`, in, 1: raw, asynchronous, active-high; increments the selected digit.
- `btn_down`, in, 1: raw, asynchronous, active-high; decrements the selected digit.
- `btn_start`, in, 1: raw, asynchronous, active-high; start, pause and resume.
- `done`, in, 1: timer-expired flag (the timer's `LED`), synchronous to `clk`.
- `I1`, out, 4: BCD minute tens of the preset.
- `I0`, out, 4: BCD minute units of the preset.
- `load`, out, 1: preset load strobe to the timer.
- `CE`, out, 1: count enable to the timer.
- `edit`, out, 2: which digit is being edited; 2'b10 = tens, 2'b01 = units, 2'b00 = none. Used for display blinking.

## Operation

Button conditioning:
- Each button passes through a 2-flop synchroniser, then a debounce counter.
- The debounced level flips only after `DB_CYCLES` consecutive cycles of a stable, differing synchronised level.
- A rising edge of the debounced level produces a 1-cycle press pulse. Releases produce no pulse.
- When several pulses fall in the same cycle, only one is acted on. Priority: start > mode > up > down. The others are dropped.

State machine. States: IDLE, EDIT_T, EDIT_U, LOAD, RUN, PAUSE.
- IDLE:
  - mode → EDIT_T.
  - start → LOAD, unless `{I1,I0}` is 00, in which case start is ignored.
- EDIT_T:
  - up: `I1` = (`I1`==9) ? 0 : `I1`+1.
  - down: `I1` = (`I1`==0) ? 9 : `I1`−1.
  - mode → EDIT_U.
  - start → LOAD, with the same 00 rule as IDLE.
- EDIT_U: same as EDIT_T but acting on `I0`; mode → IDLE.
- LOAD:
  - `load`=1 for exactly `LOAD_CYCLES` cycles, then → RUN.
  - All button pulses are ignored.
- RUN:
  - `CE`=1.
  - start → PAUSE.
  - `done`=1 → IDLE. `done` has priority over start in the same cycle.
- PAUSE:
  - `CE`=0.
  - start → RUN.
  - mode → IDLE.
  - `done`=1 → IDLE.
- up and down are ignored outside EDIT_T and EDIT_U.
- `I1` and `I0` are always valid BCD (0–9) and change only in the EDIT states.

## Timing

- Reset values: state IDLE, `I1`=0, `I0`=1 (preset 01), `load`=0, `CE`=0, `edit`=00. All debounced levels are 0 and all debounce counters are 0.
- Press latency: the pulse occurs 2 + `DB_CYCLES` cycles after the raw input is stably high. All outputs update on the clock edge that samples the pulse, so they change 1 cycle after the pulse.
- All outputs are registered.
- `load` rises on the edge that enters LOAD and falls after exactly `LOAD_CYCLES` cycles high. `CE` rises on the same edge that `load` falls. `load` and `CE` are never high together.
- `edit` is registered and matches the state: 10 in EDIT_T, 01 in EDIT_U, 00 otherwise.
- Bounce shorter than `DB_CYCLES` produces no pulse. A button held indefinitely produces exactly one pulse.
- Reset asserted mid-operation (for example, during LOAD) immediately forces all reset values. `load` drops asynchronously.
- A `done` pulse in IDLE, the EDIT states or LOAD has no effect.

## Structure

- Shared package: state encoding constants and the `edit` codes (`EDIT_NONE`, `EDIT_TENS`, `EDIT_UNITS`), plus the BCD maximum (9).
- One sub-module, `btn_debounce`:
  - Parameter `DB_CYCLES`.
  - Ports: `clk`, `reset`, `raw`, `level`, `press`.
  - Instantiated four times.
- The top level holds the FSM, the BCD digit registers and the `LOAD_CYCLES` counter. The counter is sized with `$clog2`.

## Test plan

All scenarios use `DB_CYCLES`=4 and `LOAD_CYCLES`=8.

1. Reset, then idle 20 cycles → `I1`=0, `I0`=1, `load`=0, `CE`=0, `edit`=00.
2. Raw `btn_up` toggling every 2 cycles for 30 cycles while in EDIT_T, then held high 10 cycles → exactly one increment of `I1` (0→1).
3. Press mode, then down once → `edit`=10 and `I1`=9 (wrap from 0). Press mode, then up 9 times → `edit`=01 and `I0`=0 (1→…→9→0). Press mode → `edit`=00.
4. With preset 90, press start → `load` high for exactly 8 cycles with `I1`=9, `I0`=0 stable. `CE` rises on the cycle `load` falls. Press start → `CE`=0 (PAUSE). Press start → `CE`=1. Assert `done` → `CE`=0, state IDLE.
5. With preset 00, press start → `load` stays 0 and state stays IDLE. In EDIT_U, raise start and mode raw in the same cycle → only start acts: enter LOAD, `edit`=00.
6. Assert reset low during LOAD, cycle 3 → `load` drops asynchronously. After release: `I1`=0, `I0`=1, `CE`=0.

Source files
------------

// File: rtl/time_entry_pkg.sv
// Shared definitions for the countdown-timer input front end:
// FSM state encoding, edit-indicator codes and BCD digit helpers.
package time_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EDIT_T = 3'd1,
    ST_EDIT_U = 3'd2,
    ST_LOAD   = 3'd3,
    ST_RUN    = 3'd4,
    ST_PAUSE  = 3'd5
  } state_e;

  localparam logic [1:0] EDIT_NONE  = 2'b00;
  localparam logic [1:0] EDIT_TENS  = 2'b10;
  localparam logic [1:0] EDIT_UNITS = 2'b01;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    logic [3:0] r;
    if (d >= BCD_MAX) begin
      r = BCD_ZERO;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    logic [3:0] r;
    if (d == BCD_ZERO) begin
      r = BCD_MAX;
    end else if (d > BCD_MAX) begin
      r = BCD_MAX;
    end else begin
      r = d - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/time_entry_btn_debounce.sv
// One push-button conditioner: 2-flop synchroniser, stability counter
// and a single-cycle press pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The count tracks how long the synchronised input has disagreed with the
  // debounced level; any agreement restarts it, so short bounces never flip.
  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = {CW{1'b0}};
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = {CW{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/time_entry.sv
// Countdown-timer input front end: debounced buttons drive a small FSM that
// edits a two-digit BCD minute preset and sequences the timer's load/CE.
module time_entry
  import time_entry_pkg::*;
#(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int LOAD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  input  logic       done,
  output logic [3:0] I1,
  output logic [3:0] I0,
  output logic       load,
  output logic       CE,
  output logic [1:0] edit
);

  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES + 1) : 1;
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_CYCLES - 1);

  logic [3:0] raw_s;
  logic [3:0] press_s;

  state_e        state_q;
  state_e        state_d;
  logic [3:0]    i1_q;
  logic [3:0]    i1_d;
  logic [3:0]    i0_q;
  logic [3:0]    i0_d;
  logic [LW-1:0] lcnt_q;
  logic [LW-1:0] lcnt_d;
  logic          load_q;
  logic          load_d;
  logic          ce_q;
  logic          ce_d;
  logic [1:0]    edit_q;
  logic [1:0]    edit_d;
  logic          preset_zero_s;

  assign raw_s = {btn_start, btn_mode, btn_up, btn_down};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_s[g]),
      .level(),
      .press(press_s[g])
    );
  end

  logic start_p_s;
  logic mode_p_s;
  logic up_p_s;
  logic down_p_s;

  assign start_p_s = press_s[3];
  assign mode_p_s  = press_s[2];
  assign up_p_s    = press_s[1];
  assign down_p_s  = press_s[0];

  assign preset_zero_s = (i1_q == BCD_ZERO) && (i0_q == BCD_ZERO);

  // State, digit and registered-output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      i1_q    <= 4'd0;
      i0_q    <= 4'd1;
      lcnt_q  <= {LW{1'b0}};
      load_q  <= 1'b0;
      ce_q    <= 1'b0;
      edit_q  <= EDIT_NONE;
    end else begin
      state_q <= state_d;
      i1_q    <= i1_d;
      i0_q    <= i0_d;
      lcnt_q  <= lcnt_d;
      load_q  <= load_d;
      ce_q    <= ce_d;
      edit_q  <= edit_d;
    end
  end

  // Each if-chain below encodes the start > mode > up > down priority,
  // so at most one simultaneous press is ever acted on.
  always_comb begin
    state_d = state_q;
    i1_d    = i1_q;
    i0_d    = i0_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_p_s) begin
          if (!preset_zero_s) begin
            state_d = ST_LOAD;
            lcnt_d  = {LW{1'b0}};
          end else begin
            state_d = ST_IDLE;
          end
        end else if (mode_p_s) begin
          state_d = ST_EDIT_T;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EDIT_T: begin
        if (start_p_s) begin
          if (!preset_zero_s) begin
            state_d = ST_LOAD;
            lcnt_d  = {LW{1'b0}};
          end else begin
            state_d = ST_EDIT_T;
          end
        end else if (mode_p_s) begin
          state_d = ST_EDIT_U;
        end else if (up_p_s) begin
          i1_d = bcd_inc(i1_q);
        end else if (down_p_s) begin
          i1_d = bcd_dec(i1_q);
        end else begin
          state_d = ST_EDIT_T;
        end
      end
      ST_EDIT_U: begin
        if (start_p_s) begin
          if (!preset_zero_s) begin
            state_d = ST_LOAD;
            lcnt_d  = {LW{1'b0}};
          end else begin
            state_d = ST_EDIT_U;
          end
        end else if (mode_p_s) begin
          state_d = ST_IDLE;
        end else if (up_p_s) begin
          i0_d = bcd_inc(i0_q);
        end else if (down_p_s) begin
          i0_d = bcd_dec(i0_q);
        end else begin
          state_d = ST_EDIT_U;
        end
      end
      ST_LOAD: begin
        if (lcnt_q == LOAD_LAST) begin
          state_d = ST_RUN;
          lcnt_d  = {LW{1'b0}};
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
      ST_RUN: begin
        if (done) begin
          state_d = ST_IDLE;
        end else if (start_p_s) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (done) begin
          state_d = ST_IDLE;
        end else if (start_p_s) begin
          state_d = ST_RUN;
        end else if (mode_p_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flip on the very edge
  // that changes state; load falls on the same edge CE rises.
  always_comb begin
    load_d = 1'b0;
    ce_d   = 1'b0;
    edit_d = EDIT_NONE;
    case (state_d)
      ST_LOAD:   load_d = 1'b1;
      ST_RUN:    ce_d   = 1'b1;
      ST_EDIT_T: edit_d = EDIT_TENS;
      ST_EDIT_U: edit_d = EDIT_UNITS;
      default: begin
        load_d = 1'b0;
        ce_d   = 1'b0;
        edit_d = EDIT_NONE;
      end
    endcase
  end

  assign I1   = i1_q;
  assign I0   = i0_q;
  assign load = load_q;
  assign CE   = ce_q;
  assign edit = edit_q;

endmodule

// File: tb/tb_time_entry.sv
// Directed bench for time_entry with DB_CYCLES=4, LOAD_CYCLES=8.
module tb_time_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic       btn_start;
  logic       done;
  logic [3:0] I1;
  logic [3:0] I0;
  logic       load;
  logic       CE;
  logic [1:0] edit;

  int errors = 0;
  int checks = 0;

  localparam int B_MODE  = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_START = 3;

  time_entry #(
    .DB_CYCLES  (4),
    .LOAD_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_start(btn_start),
    .done     (done),
    .I1       (I1),
    .I0       (I0),
    .load     (load),
    .CE       (CE),
    .edit     (edit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_MODE:  btn_mode  = v;
      B_UP:    btn_up    = v;
      B_DOWN:  btn_down  = v;
      B_START: btn_start = v;
      default: ;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc(12);
    set_btn(b, 1'b0);
    cyc(12);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n;
    logic stable;
    logic seen;

    reset = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    btn_start = 1'b0; done = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(20);
    check("rst_I1", 8'(I1), 8'h0);
    check("rst_I0", 8'(I0), 8'h1);
    check("rst_load", 8'(load), 8'h0);
    check("rst_CE", 8'(CE), 8'h0);
    check("rst_edit", 8'(edit), 8'h0);

    // Bounce on up while editing tens, then a solid hold.
    press(B_MODE);
    check("edit_tens", 8'(edit), 8'h2);
    for (int k = 0; k < 15; k++) begin
      btn_up = ~btn_up;
      cyc(2);
    end
    check("bounce_no_inc", 8'(I1), 8'h0);
    cyc(30);
    check("hold_one_inc", 8'(I1), 8'h1);
    btn_up = 1'b0;
    cyc(12);
    check("release_no_inc", 8'(I1), 8'h1);

    // Fresh reset, then digit wrap-around editing.
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(5);
    check("rst2_I1", 8'(I1), 8'h0);
    press(B_MODE);
    check("t3_edit_tens", 8'(edit), 8'h2);
    press(B_DOWN);
    check("down_wrap_I1", 8'(I1), 8'h9);
    press(B_MODE);
    check("t3_edit_units", 8'(edit), 8'h1);
    for (int k = 0; k < 9; k++) press(B_UP);
    check("up_wrap_I0", 8'(I0), 8'h0);
    check("I1_kept", 8'(I1), 8'h9);
    press(B_MODE);
    check("t3_edit_none", 8'(edit), 8'h0);
    press(B_UP);
    check("idle_up_ignored", 8'({I1, I0}), 8'h90);

    // Load window, run, pause, resume, done.
    btn_start = 1'b1;
    t = 0;
    while (load !== 1'b1 && t < 40) begin cyc(1); t++; end
    check("load_rise", 8'(load), 8'h1);
    n = 0;
    stable = 1'b1;
    while (load === 1'b1 && n < 40) begin
      if (I1 !== 4'd9 || I0 !== 4'd0 || CE !== 1'b0) stable = 1'b0;
      n++;
      cyc(1);
    end
    check("load_len", 8'(n), 8'd8);
    check("load_stable", 8'(stable), 8'h1);
    check("ce_at_load_fall", 8'(CE), 8'h1);
    btn_start = 1'b0;
    cyc(12);
    check("run_CE", 8'(CE), 8'h1);
    press(B_START);
    check("pause_CE", 8'(CE), 8'h0);
    press(B_START);
    check("resume_CE", 8'(CE), 8'h1);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    cyc(1);
    check("done_CE", 8'(CE), 8'h0);
    check("done_load", 8'(load), 8'h0);
    check("done_edit", 8'(edit), 8'h0);
    press(B_MODE);
    check("done_is_idle", 8'(edit), 8'h2);

    // Preset 00 blocks start.
    press(B_UP);
    check("I1_to_0", 8'(I1), 8'h0);
    press(B_MODE);
    press(B_MODE);
    check("back_idle", 8'(edit), 8'h0);
    btn_start = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      cyc(1);
      if (load !== 1'b0 || CE !== 1'b0) seen = 1'b1;
    end
    btn_start = 1'b0;
    cyc(12);
    check("zero_no_load", 8'(seen), 8'h0);
    press(B_MODE);
    check("zero_still_idle", 8'(edit), 8'h2);
    press(B_MODE);
    press(B_UP);
    check("I0_to_1", 8'(I0), 8'h1);

    // Simultaneous start+mode in EDIT_U: start wins.
    btn_start = 1'b1;
    btn_mode  = 1'b1;
    t = 0;
    while (load !== 1'b1 && t < 40) begin cyc(1); t++; end
    check("prio_load", 8'(load), 8'h1);
    check("prio_edit", 8'(edit), 8'h0);
    check("prio_I0", 8'(I0), 8'h1);
    cyc(2);
    check("load_mid", 8'(load), 8'h1);

    // Asynchronous reset during LOAD.
    reset = 1'b0;
    #1;
    check("async_load_drop", 8'(load), 8'h0);
    check("async_I0", 8'(I0), 8'h1);
    btn_start = 1'b0;
    btn_mode  = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(20);
    check("post_I1", 8'(I1), 8'h0);
    check("post_I0", 8'(I0), 8'h1);
    check("post_CE", 8'(CE), 8'h0);
    check("post_load", 8'(load), 8'h0);
    check("post_edit", 8'(edit), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
